mont_mult: RTL and testbench

- Bit-serial radix-2 Montgomery multiplier. Computes result = a·b·R⁻¹ mod N.
- Consumes the R/2 and R² mod N values produced by the R-setup block, closing the loop on the Montgomery datapath.
- With b = R² mod N it converts into the Montgomery domain. With b = 1 it converts out of the Montgomery domain. Otherwise it multiplies two Montgomery-domain operands.
- Sits beside the modulo and R-setup blocks in the modular-arithmetic path.

---
 rtl/mont_pkg.sv | 18 +
 rtl/mont_step.sv | 22 ++
 rtl/mont_mult.sv | 130 +++++++++++++
 tb/tb_mont_mult.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery datapath: default width, FSM state encoding
// and a power-of-two helper used for operand checking.
package mont_pkg;

    localparam int unsigned MONT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINAL,
        DONE
    } mont_state_t;

    function automatic logic is_pow2(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_i*b + q*N) / 2, q chosen so the sum is even.
module mont_step #(
    parameter int unsigned DATA_WIDTH = mont_pkg::MONT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH+1:0] s,
    input  logic                  a_bit,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] n,
    output logic [DATA_WIDTH+1:0] s_next
);

    logic [DATA_WIDTH+1:0] t;
    logic [DATA_WIDTH+1:0] u;

    // With S < 2N and b < N, T + N < 4N, so DATA_WIDTH+2 bits never overflow.
    always_comb begin
        t      = s + (a_bit ? {2'b00, b} : '0);
        u      = t + (t[0] ? {2'b00, n} : '0);
        s_next = u >> 1;
    end

endmodule

// File: rtl/mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*R^-1 mod N, one operand bit per cycle.
module mont_mult
    import mont_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mont_pkg::MONT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulant,
    input  logic [DATA_WIDTH-1:0] r_div_2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    mont_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] n_q, n_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH+1:0] s_q, s_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  a_bit;
    logic [DATA_WIDTH+1:0] s_step;
    logic [DATA_WIDTH+1:0] n_ext;

    assign a_bit = |(a_q & mask_q);
    assign n_ext = {2'b00, n_q};

    mont_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .s     (s_q),
        .a_bit (a_bit),
        .b     (b_q),
        .n     (n_q),
        .s_next(s_step)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        r_d      = r_q;
        mask_d   = mask_q;
        s_d      = s_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    n_d    = modulant;
                    r_d    = r_div_2;
                    s_d    = '0;
                    mask_d = DATA_WIDTH'(1);
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    // Even modulus or malformed R/2 cannot yield a valid Montgomery product.
                    if (!modulant[0] || !is_pow2(32'(r_div_2))) begin
                        state_d  = DONE;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                s_d = s_step;
                if (mask_q == r_q) begin
                    state_d = FINAL;
                end else begin
                    mask_d = mask_q << 1;
                end
            end
            FINAL: begin
                result_d = DATA_WIDTH'((s_q >= n_ext) ? (s_q - n_ext) : s_q);
                done_d   = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            mask_q   <= '0;
            s_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            r_q      <= r_d;
            mask_q   <= mask_d;
            s_q      <= s_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = (state_q == ITER) || (state_q == FINAL);

endmodule

// File: tb/tb_mont_mult.sv
// Directed bench for mont_mult with hand-computed Montgomery products.
module tb_mont_mult;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] modulant;
    logic [DW-1:0] r_div_2;
    logic [DW-1:0] result;
    logic          done;
    logic          busy;
    logic          err;

    int checks   = 0;
    int failures = 0;

    mont_mult #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .modulant(modulant),
        .r_div_2 (r_div_2),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives a request and returns #1 after the edge that samples start (edge 0).
    task automatic start_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                            input logic [DW-1:0] tn, input logic [DW-1:0] tr);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        modulant = tn;
        r_div_2  = tr;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts further edges until done rises, plus cycles spent with busy high.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1 edges++;
        end
    endtask

    int edges;
    int busy_cnt;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        modulant = '0;
        r_div_2  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", 32'(result), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5*7*16^-1 mod 13 = 3
        start_op(8'd5, 8'd7, 8'd13, 8'd8);
        wait_done(edges, busy_cnt);
        check("t1_latency", 32'(edges), 32'd5);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd5);
        check("t1_result", 32'(result), 32'd3);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 14*14*16^-1 mod 15 = 1, final subtraction from S=16
        start_op(8'd14, 8'd14, 8'd15, 8'd8);
        wait_done(edges, busy_cnt);
        check("t2_result", 32'(result), 32'd1);
        check("t2_latency", 32'(edges), 32'd5);

        // To Montgomery domain with R^2 mod 13 = 9, then back out with b=1
        start_op(8'd5, 8'd9, 8'd13, 8'd8);
        wait_done(edges, busy_cnt);
        check("t3_to_domain", 32'(result), 32'd2);
        start_op(8'd2, 8'd1, 8'd13, 8'd8);
        check("t3_done_drops", 32'(done), 32'd0);
        check("t3_busy_rises", 32'(busy), 32'd1);
        wait_done(edges, busy_cnt);
        check("t3_from_domain", 32'(result), 32'd5);

        // 250*250*256^-1 mod 251 = 201
        start_op(8'd250, 8'd250, 8'd251, 8'd128);
        wait_done(edges, busy_cnt);
        check("t4_latency", 32'(edges), 32'd9);
        check("t4_result", 32'(result), 32'd201);

        // Even modulus
        start_op(8'd5, 8'd7, 8'd12, 8'd8);
        @(posedge clk);
        #1;
        check("t5_evenN_done", 32'(done), 32'd1);
        check("t5_evenN_err", 32'(err), 32'd1);
        check("t5_evenN_result", 32'(result), 32'd0);
        check("t5_evenN_busy", 32'(busy), 32'd0);

        // Non-power-of-two R/2
        start_op(8'd5, 8'd7, 8'd13, 8'd6);
        @(posedge clk);
        #1;
        check("t5_r6_err", 32'(err), 32'd1);
        check("t5_r6_done", 32'(done), 32'd1);

        // start re-asserted with new inputs during ITER is ignored
        start_op(8'd5, 8'd7, 8'd13, 8'd8);
        @(negedge clk);
        start    = 1'b1;
        a        = 8'd1;
        b        = 8'd2;
        modulant = 8'd11;
        r_div_2  = 8'd6;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, busy_cnt);
        check("t5_ignore_latency", 32'(edges + 2), 32'd5);
        check("t5_ignore_result", 32'(result), 32'd3);
        check("t5_ignore_err", 32'(err), 32'd0);

        // Reset during edge 2 of an operation; prior result of 3 must be cleared
        start_op(8'd5, 8'd7, 8'd13, 8'd8);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_stays_idle", 32'(done), 32'd0);
        start_op(8'd5, 8'd7, 8'd13, 8'd8);
        wait_done(edges, busy_cnt);
        check("t6_rerun_latency", 32'(edges), 32'd5);
        check("t6_rerun_result", 32'(result), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
